// File: rtl/ss_pkg.sv
//==============================================================================
// Module      : ss_pkg
// Description : Shared helpers for the signed stochastic add/sub datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ss_pkg;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

    // Bits needed to hold a popcount of n inputs (0..n inclusive).
    function automatic int ss_pw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : ss_pkg

`default_nettype wire

// File: rtl/ss_popcount.sv
//==============================================================================
// Module      : ss_popcount
// Description : Combinational population count of an N-bit vector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ss_popcount
    import ss_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ss_pw(N)
) (
    input  logic [N-1:0]  i_bits,
    output logic [PW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + PW'(i_bits[i]);
        end
    end

endmodule : ss_popcount

`default_nettype wire

// File: rtl/ss_addsub_n.sv
//==============================================================================
// Module      : ss_addsub_n
// Description : N-input signed stochastic adder/subtractor with saturating
//               sign-magnitude accumulator and threshold-gated output.
//               Define SS_ADDSUB_PIPE_EN to register the popcounts (latency 2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ss_addsub_n
    import ss_pkg::*;
#(
    parameter int N       = 4,
    parameter int CNT_W   = 4,
    parameter int CNT_MIN = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INIT,
    input  logic             EN,
    input  logic [N-1:0]     IN,
    input  logic [N-1:0]     SIGN,
    input  logic             R_condition,
    output logic             OUT,
    output logic             SIGN_out,
    output logic [CNT_W-1:0] COUNT,
    output logic             SAT
);

    localparam int              PW        = ss_pw(N);
    localparam int              XW        = CNT_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_min = CNT_W'(CNT_MIN);

    logic [PW-1:0]    w_p;
    logic [PW-1:0]    w_q;
    logic [PW-1:0]    w_s_p;
    logic [PW-1:0]    w_s_q;
    logic             w_s_en;
    logic             w_s_init;
    logic             w_s_rc;

    logic [CNT_W-1:0] r_count;
    logic             r_sign;
    logic             r_out;

    ss_popcount #(.N(N), .PW(PW)) u_pop_p (
        .i_bits  (IN & ~SIGN),
        .o_count (w_p)
    );

    ss_popcount #(.N(N), .PW(PW)) u_pop_q (
        .i_bits  (IN & SIGN),
        .o_count (w_q)
    );

`ifdef SS_ADDSUB_PIPE_EN
    logic [PW-1:0] r_p;
    logic [PW-1:0] r_q;
    logic          r_en;
    logic          r_init;
    logic          r_rc;

    // Controls are staged alongside the counts so each vector keeps its own EN/INIT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p    <= '0;
            r_q    <= '0;
            r_en   <= 1'b0;
            r_init <= 1'b0;
            r_rc   <= 1'b0;
        end else begin
            r_p    <= w_p;
            r_q    <= w_q;
            r_en   <= EN;
            r_init <= INIT;
            r_rc   <= R_condition;
        end
    end

    assign w_s_p    = r_p;
    assign w_s_q    = r_q;
    assign w_s_en   = r_en;
    assign w_s_init = r_init;
    assign w_s_rc   = r_rc;
`else
    assign w_s_p    = w_p;
    assign w_s_q    = w_q;
    assign w_s_en   = EN;
    assign w_s_init = INIT;
    assign w_s_rc   = R_condition;
`endif

    logic [XW-1:0]    w_p_ext;
    logic [XW-1:0]    w_q_ext;
    logic [XW-1:0]    w_d;
    logic [XW-1:0]    w_sum;
    logic [CNT_W-1:0] w_d_n;
    logic [CNT_W-1:0] w_add;
    logic [CNT_W-1:0] w_sub;
    logic [CNT_W-1:0] w_cross;
    logic             w_dsgn;

    assign w_p_ext = XW'(w_s_p);
    assign w_q_ext = XW'(w_s_q);
    assign w_dsgn  = (w_s_q > w_s_p);
    assign w_d     = w_dsgn ? (w_q_ext - w_p_ext) : (w_p_ext - w_q_ext);
    assign w_sum   = XW'(r_count) + w_d;
    // A carry out of the CNT_W-bit field means the sum passed LIM; clamp to all ones.
    assign w_add   = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    // D never exceeds N < 2^CNT_W, so the narrowed copy is exact.
    assign w_d_n   = w_d[CNT_W-1:0];
    assign w_sub   = r_count - w_d_n;
    assign w_cross = w_d_n - r_count;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sgn_nxt;
    logic             w_out_nxt;

    always_comb begin
        w_cnt_nxt = r_count;
        w_sgn_nxt = r_sign;
        w_out_nxt = 1'b0;
        if (w_s_init) begin
            w_cnt_nxt = '0;
        end else if (w_s_en) begin
            w_out_nxt = (r_count > c_cnt_min) &&
                        ((r_sign == SIGN_NEG) ? (w_s_q > w_s_p) : (w_s_p > w_s_q));
            if (w_s_p == w_s_q) begin
                w_cnt_nxt = r_count;
            end else if (w_dsgn == r_sign) begin
                w_cnt_nxt = w_add;
            end else if (w_d < XW'(r_count)) begin
                w_cnt_nxt = w_sub;
            end else if (w_d > XW'(r_count)) begin
                w_cnt_nxt = w_cross;
                w_sgn_nxt = w_dsgn;
            end else begin
                w_cnt_nxt = '0;
                if (w_s_rc) begin
                    w_sgn_nxt = w_dsgn;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
            r_sign  <= SIGN_POS;
            r_out   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_sign  <= w_sgn_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign COUNT    = r_count;
    assign SIGN_out = r_sign;
    assign OUT      = r_out;
    assign SAT      = &r_count;

endmodule : ss_addsub_n

`default_nettype wire

// File: tb/tb_ss_addsub_n.sv
//==============================================================================
// Module      : tb_ss_addsub_n
// Description : Directed self-checking bench for ss_addsub_n (N=4, CNT_W=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ss_addsub_n;

`ifdef SS_ADDSUB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       en;
    logic [3:0] in_v;
    logic [3:0] sign_v;
    logic       rc;
    logic       out_o;
    logic       sign_o;
    logic [3:0] count_o;
    logic       sat_o;

    int checks;
    int failures;

    ss_addsub_n #(.N(4), .CNT_W(4), .CNT_MIN(1)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .INIT        (init),
        .EN          (en),
        .IN          (in_v),
        .SIGN        (sign_v),
        .R_condition (rc),
        .OUT         (out_o),
        .SIGN_out    (sign_o),
        .COUNT       (count_o),
        .SAT         (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        init   = 1'b0;
        en     = 1'b0;
        in_v   = 4'b0000;
        sign_v = 4'b0000;
        rc     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One vector, then idle until its result is visible; sample 1 unit after the edge.
    task automatic step(input logic [3:0] i, input logic [3:0] s,
                        input logic e, input logic ini, input logic r);
        in_v   = i;
        sign_v = s;
        en     = e;
        init   = ini;
        rc     = r;
        @(posedge clk);
        for (int k = 1; k < LAT; k++) begin
            set_idle();
            @(posedge clk);
        end
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        init   = 1'b0;
        rc     = 1'($urandom_range(0, 1));
        in_v   = 4'($urandom_range(0, 15));
        sign_v = 4'($urandom_range(0, 15));
        repeat (3) @(posedge clk);
        #1;
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        checks++; if (sign_o !== 1'b0)  begin failures++; $display("FAIL rst_sign: got %0b expected 0", sign_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL rst_out: got %0b expected 0", out_o); end
        checks++; if (sat_o !== 1'b0)   begin failures++; $display("FAIL rst_sat: got %0b expected 0", sat_o); end
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL first_count: got %0d expected 2", count_o); end
        checks++; if (sign_o !== 1'b0)  begin failures++; $display("FAIL first_sign: got %0b expected 0", sign_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL first_out: got %0b expected 0", out_o); end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL mid_pre_count: got %0d expected 8", count_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL mid_async_count: got %0d expected 0", count_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL mid_async_out: got %0b expected 0", out_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        logic [3:0] nc [6] = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15};
        logic [3:0] pc [6] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
        logic       no [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       po [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_c;
        logic       exp_o;
        logic       exp_s;
        do_reset();
        in_v   = 4'b1111;
        sign_v = 4'b0000;
        en     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            exp_c = (LAT == 1) ? nc[k] : pc[k];
            exp_o = (LAT == 1) ? no[k] : po[k];
            exp_s = (exp_c == 4'd15);
            checks++; if (count_o !== exp_c) begin failures++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, count_o, exp_c); end
            checks++; if (out_o !== exp_o)   begin failures++; $display("FAIL sat_out[%0d]: got %0b expected %0b", k, out_o, exp_o); end
            checks++; if (sat_o !== exp_s)   begin failures++; $display("FAIL sat_flag[%0d]: got %0b expected %0b", k, sat_o, exp_s); end
        end
        set_idle();
    endtask

    task automatic test_zero_crossing();
        do_reset();
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL zc_rc0_count: got %0d expected 0", count_o); end
        checks++; if (sign_o !== 1'b0)  begin failures++; $display("FAIL zc_rc0_sign: got %0b expected 0", sign_o); end
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL zc_rebuild_count: got %0d expected 2", count_o); end
        step(4'b1111, 4'b1110, 1'b1, 1'b0, 1'b1);
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL zc_rc1_count: got %0d expected 0", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL zc_rc1_sign: got %0b expected 1", sign_o); end
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL zc_cross_count: got %0d expected 1", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL zc_cross_sign: got %0b expected 1", sign_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL zc_cross_out: got %0b expected 0", out_o); end
    endtask

    task automatic test_threshold();
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL thr_gate_out: got %0b expected 0", out_o); end
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL thr_gate_count: got %0d expected 2", count_o); end
        step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        checks++; if (out_o !== 1'b1)   begin failures++; $display("FAIL thr_pass_out: got %0b expected 1", out_o); end
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL thr_pass_count: got %0d expected 3", count_o); end
    endtask

    task automatic test_init_en();
        do_reset();
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd9) begin failures++; $display("FAIL ie_pre_count: got %0d expected 9", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL ie_pre_sign: got %0b expected 1", sign_o); end
        checks++; if (out_o !== 1'b1)   begin failures++; $display("FAIL ie_pre_out: got %0b expected 1", out_o); end
        step(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL ie_init_count: got %0d expected 0", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL ie_init_sign: got %0b expected 1", sign_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL ie_init_out: got %0b expected 0", out_o); end
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL ie_rebuild_count: got %0d expected 8", count_o); end
        checks++; if (out_o !== 1'b1)   begin failures++; $display("FAIL ie_rebuild_out: got %0b expected 1", out_o); end
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL ie_hold_count: got %0d expected 8", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL ie_hold_sign: got %0b expected 1", sign_o); end
        checks++; if (out_o !== 1'b0)   begin failures++; $display("FAIL ie_hold_out: got %0b expected 0", out_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL b2b_cancel_count: got %0d expected 0", count_o); end
        checks++; if (sign_o !== 1'b0)  begin failures++; $display("FAIL b2b_cancel_sign: got %0b expected 0", sign_o); end
        step(4'b0111, 4'b0100, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL b2b_small_count: got %0d expected 1", count_o); end
        step(4'b1010, 4'b1010, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 4'b1100, 1'b1, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL b2b_hold_count: got %0d expected 1", count_o); end
        checks++; if (sign_o !== 1'b1)  begin failures++; $display("FAIL b2b_hold_sign: got %0b expected 1", sign_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_idle();
        #1;
        test_reset();
        test_midstream_reset();
        test_saturation();
        test_zero_crossing();
        test_threshold();
        test_init_en();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ss_addsub_n

`default_nettype wire

// File: doc/ss_addsub_n.md
# ss_addsub_n

N-input signed stochastic adder/subtractor for the fully connected SNN datapath; generalises the 2-input sign-tracking adder to any input count. Each cycle the block counts active positive and negative stochastic input bits, accumulates their net difference in a saturating sign-magnitude counter, and emits a signed output bitstream gated by a minimum-magnitude threshold. It sits between synapse multipliers and the neuron activation stage.

## Interface
- N, 4: number of signed stochastic inputs (>= 2)
- CNT_W, 4: magnitude counter width; must exceed PW = $clog2(N+1)
- CNT_MIN, 1: OUT is suppressed while magnitude <= CNT_MIN
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- INIT  in  1  synchronous re-initialise of the counter
- EN  in  1  accumulate enable; low holds all state
- IN  in  N  stochastic input bits
- SIGN  in  N  per-input sign, 1 = negative
- R_condition  in  1  tie-break on exact cancellation to zero
- OUT  out  1  output stochastic bit (registered)
- SIGN_out  out  1  accumulated sign, 1 = negative
- COUNT  out  CNT_W  accumulated magnitude
- SAT  out  1  high while COUNT == 2^CNT_W-1

## Operation
- P = popcount(IN & ~SIGN), Q = popcount(IN & SIGN), each PW bits; D = |P-Q|, Dsgn = (Q>P).
- Saturation limit LIM = 2^CNT_W-1; all magnitude arithmetic done at CNT_W+1 bits, no wrap.
- Update, on enabled cycle with INIT low, in priority order:
  - P == Q: COUNT, SIGN_out hold.
  - Dsgn == SIGN_out: COUNT <= min(COUNT+D, LIM).
  - D < COUNT: COUNT <= COUNT-D, sign holds.
  - D > COUNT: COUNT <= D-COUNT, SIGN_out <= Dsgn (zero crossing).
  - D == COUNT: COUNT <= 0; SIGN_out <= Dsgn if R_condition else holds.
- OUT <= (COUNT > CNT_MIN) && (SIGN_out ? Q>P : P>Q), using pre-update COUNT/SIGN_out of the same cycle.
- INIT (sync, overrides EN): COUNT <= 0, OUT <= 0, SIGN_out holds.
- EN low: COUNT, SIGN_out hold; OUT <= 0.
- SAT is combinational from COUNT.
- Reset (RST_N low, async): COUNT = 0, SIGN_out = 0, OUT = 0, SAT = 0, pipeline registers = 0. Reset asserted mid-stream discards all accumulated state immediately; first update occurs on the first rising edge with RST_N high.

## Timing
- Without pipeline: IN/SIGN sampled at edge k; COUNT, SIGN_out, OUT reflect them after edge k (latency 1).
- With pipeline: P, Q, EN, INIT, R_condition registered at edge k, applied at edge k+1 (latency 2); stage controls travel with their data.
- Throughput one input vector per cycle; no handshake, no stall.
- Saturation: further same-sign input at COUNT == LIM leaves COUNT at LIM; SAT stays high.

## Configuration
- SS_ADDSUB_PIPE_EN defined: popcount register stage inserted, latency 2, popcount off the accumulator timing path.
- Not defined: popcount feeds accumulator combinationally, latency 1. Update rules identical in both builds.

## Structure
- Shared package ss_pkg: popcount width function (clog2 of N+1), sign encoding constants (SIGN_POS = 0, SIGN_NEG = 1).
- One sub-module ss_popcount (parameter N, N-bit in, PW-bit count), instanced twice for P and Q.
- Accumulator, tie-break, output gating in the top module.

## Test plan
- N=4, CNT_W=4, CNT_MIN=1, no pipeline throughout unless noted.
- Reset: hold RST_N low with random inputs -> COUNT=0, SIGN_out=0, OUT=0, SAT=0; release, IN=4'b0011 SIGN=0 -> COUNT=2 after one edge.
- Saturation: IN=4'b1111 SIGN=0 for 5 cycles -> COUNT 4, 8, 12, 15, 15; SAT high from cycle 4; OUT=1 from cycle 2.
- Zero crossing: COUNT=2 positive, apply IN=4'b1111 SIGN=4'b1110 (P=1,Q=3, D=2) with R_condition=0 -> COUNT=0, SIGN_out=0; repeat from COUNT=2 with R_condition=1 -> SIGN_out=1; from COUNT=1 -> COUNT=1, SIGN_out=1.
- Threshold gating: COUNT=1 positive, P=1 Q=0 -> OUT=0 that edge, COUNT=2; next identical vector -> OUT=1.
- INIT/EN: COUNT=9 negative, INIT=1 -> COUNT=0, SIGN_out=1, OUT=0; EN=0 with P=4 -> all state held, OUT=0.
- Pipeline build: same saturation stimulus -> identical COUNT sequence shifted one cycle later.
